// File: rtl/vec_add_if.sv
// rtl/vec_add_if.sv - block control and FIFO stream signals of vec_add
interface vec_add_if;
    logic        ap_start;
    logic        ap_done;
    logic        ap_idle;
    logic        ap_ready;
    logic [63:0] n;
    logic [32:0] a_s_dout;
    logic        a_s_empty_n;
    logic        a_s_read;
    logic [32:0] b_s_dout;
    logic        b_s_empty_n;
    logic        b_s_read;
    logic [32:0] c_s_din;
    logic        c_s_full_n;
    logic        c_s_write;
    logic [32:0] c_peek;

    modport slave (
        input  ap_start, n,
        input  a_s_dout, a_s_empty_n,
        input  b_s_dout, b_s_empty_n,
        input  c_s_full_n,
        output ap_done, ap_idle, ap_ready,
        output a_s_read, b_s_read,
        output c_s_din, c_s_write, c_peek
    );

    modport master (
        output ap_start, n,
        output a_s_dout, a_s_empty_n,
        output b_s_dout, b_s_empty_n,
        output c_s_full_n,
        input  ap_done, ap_idle, ap_ready,
        input  a_s_read, b_s_read,
        input  c_s_din, c_s_write, c_peek
    );
endinterface

// File: rtl/vec_add.sv
// rtl/vec_add.sv - streaming float32 adder, c[k] = a[k] + b[k-1], EoT-terminated
module vec_add (
    input  logic      ap_clk,
    input  logic      ap_rst_n,
    vec_add_if.slave  bus
);
    typedef enum logic [2:0] {S_IDLE, S_READ, S_CALC, S_WRITE, S_CLOSE, S_DONE} state_t;

    state_t      state;
    logic [31:0] a_data, b_data, b_prev, sum;
    logic        pop;
    logic [32:0] c_word;
    logic        unused_n;

    // Flush-to-zero binary32 add, round-to-nearest-even, three guard bits.
    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        logic        swap, sx, sy, rnd, found;
        logic [7:0]  ex, ey, d;
        logic [26:0] xm, ym, yal, nm;
        logic [53:0] ysh;
        logic [27:0] s;
        logic [4:0]  lz;
        logic signed [9:0] e;
        logic [30:0] body;
        logic [31:0] r;
        a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        a_zero = (a[30:23] == 8'd0);
        b_zero = (b[30:23] == 8'd0);
        swap   = b[30:0] > a[30:0];
        sx     = swap ? b[31] : a[31];
        sy     = swap ? a[31] : b[31];
        ex     = swap ? b[30:23] : a[30:23];
        ey     = swap ? a[30:23] : b[30:23];
        xm     = {1'b1, (swap ? b[22:0] : a[22:0]), 3'b000};
        ym     = {1'b1, (swap ? a[22:0] : b[22:0]), 3'b000};
        d      = ex - ey;
        ysh    = {ym, 27'd0} >> ((d > 8'd27) ? 8'd27 : d);
        yal    = {ysh[53:28], ysh[27] | (|ysh[26:0])};
        lz     = 5'd0;
        found  = 1'b0;
        if (sx == sy) begin
            s  = {1'b0, xm} + {1'b0, yal};
            nm = s[27] ? {s[27:2], s[1] | s[0]} : s[26:0];
            e  = $signed({2'b00, ex}) + $signed({9'd0, s[27]});
        end else begin
            s = {1'b0, xm} - {1'b0, yal};
            for (int i = 26; i >= 0; i--) begin
                if (!found && s[i]) begin
                    lz    = 5'(26 - i);
                    found = 1'b1;
                end
            end
            nm = s[26:0] << lz;
            e  = $signed({2'b00, ex}) - $signed({5'd0, lz});
        end
        rnd  = nm[2] & (nm[3] | nm[1] | nm[0]);
        // A mantissa carry ripples into the exponent, including up to Inf.
        body = {e[7:0], nm[25:3]} + {30'd0, rnd};
        if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31])))
            r = 32'h7FC0_0000;
        else if (a_inf)
            r = a;
        else if (b_inf)
            r = b;
        else if (a_zero && b_zero)
            r = {a[31] & b[31], 31'd0};
        else if (a_zero)
            r = b;
        else if (b_zero)
            r = a;
        else if (!nm[26])
            r = 32'h0000_0000;
        else if (e >= 10'sd255)
            r = {sx, 8'hFF, 23'd0};
        else if (e <= 10'sd0)
            r = {sx, 31'd0};
        else
            r = {sx, body};
        return r;
    endfunction

    assign pop           = (state == S_READ) && bus.a_s_empty_n && bus.b_s_empty_n;
    assign bus.a_s_read  = pop;
    assign bus.b_s_read  = pop;
    assign bus.c_s_write = ((state == S_WRITE) || (state == S_CLOSE)) && bus.c_s_full_n;
    assign bus.ap_idle   = (state == S_IDLE);
    assign bus.ap_done   = (state == S_DONE);
    assign bus.ap_ready  = (state == S_DONE);
    assign bus.c_s_din   = c_word;
    assign bus.c_peek    = c_word;
    assign unused_n      = ^bus.n;

    always_comb begin
        c_word = 33'd0;
        case (state)
            S_WRITE: c_word = {1'b0, sum};
            S_CLOSE: c_word = {1'b1, 32'd0};
            default: c_word = 33'd0;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state  <= S_IDLE;
            a_data <= 32'd0;
            b_data <= 32'd0;
            b_prev <= 32'd0;
            sum    <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.ap_start) begin
                        b_prev <= 32'd0;
                        state  <= S_READ;
                    end
                end
                S_READ: begin
                    if (pop) begin
                        a_data <= bus.a_s_dout[31:0];
                        b_data <= bus.b_s_dout[31:0];
                        state  <= (bus.a_s_dout[32] || bus.b_s_dout[32]) ? S_CLOSE : S_CALC;
                    end
                end
                S_CALC: begin
                    sum    <= fadd(a_data, b_prev);
                    b_prev <= b_data;
                    state  <= S_WRITE;
                end
                S_WRITE: begin
                    if (bus.c_s_full_n) state <= S_READ;
                end
                S_CLOSE: begin
                    if (bus.c_s_full_n) state <= S_DONE;
                end
                S_DONE: begin
                    // A start still pending at completion chains straight into the next run.
                    if (bus.ap_start) begin
                        b_prev <= 32'd0;
                        state  <= S_READ;
                    end else begin
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vec_add.sv
// tb/tb_vec_add.sv - directed table-driven bench for vec_add
module tb_vec_add;
    logic ap_clk = 1'b0;
    logic ap_rst_n = 1'b0;
    always #5 ap_clk = ~ap_clk;

    vec_add_if bus();
    vec_add dut (.ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .bus(bus));

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
    } vec_t;

    vec_t        tbl[17];
    logic [32:0] a_q[$];
    logic [32:0] b_q[$];
    logic [32:0] c_got[$];
    bit          a_hold, b_hold, c_hold;
    int          total, bad, cyc, dc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic refresh();
        bus.a_s_dout    = (a_q.size() != 0) ? a_q[0] : 33'd0;
        bus.b_s_dout    = (b_q.size() != 0) ? b_q[0] : 33'd0;
        bus.a_s_empty_n = (a_q.size() != 0) && !a_hold;
        bus.b_s_empty_n = (b_q.size() != 0) && !b_hold;
        bus.c_s_full_n  = !c_hold;
    endtask

    // One clock: sample handshakes mid-cycle, apply the FIFO effects after the edge.
    task automatic tick();
        logic ra, rb, wr, re;
        logic [32:0] din;
        #1;
        ra  = bus.a_s_read;
        rb  = bus.b_s_read;
        wr  = bus.c_s_write;
        din = bus.c_s_din;
        @(posedge ap_clk);
        re = ap_rst_n;
        #1;
        if (re) begin
            if (ra && a_q.size() != 0) void'(a_q.pop_front());
            if (rb && b_q.size() != 0) void'(b_q.pop_front());
            if (wr) c_got.push_back(din);
        end
        refresh();
        cyc++;
        @(negedge ap_clk);
    endtask

    task automatic flush();
        a_q.delete();
        b_q.delete();
        c_got.delete();
        a_hold = 0;
        b_hold = 0;
        c_hold = 0;
        refresh();
    endtask

    task automatic load(input int first, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            a_q.push_back({1'b0, tbl[first+i].a});
            b_q.push_back({1'b0, tbl[first+i].b});
        end
        a_q.push_back({1'b1, 32'd0});
        b_q.push_back({1'b1, 32'd0});
        refresh();
    endtask

    task automatic start_run();
        bus.ap_start = 1'b1;
        cyc = 0;
        for (int i = 0; i < 20 && bus.ap_idle; i++) tick();
        bus.ap_start = 1'b0;
        check("run_started", 64'(bus.ap_idle), 64'd0);
    endtask

    task automatic wait_done(input int budget, output int done_cyc);
        bit seen;
        seen = 0;
        done_cyc = -1;
        for (int i = 0; i < budget; i++) begin
            if (bus.ap_done) begin
                seen = 1;
                done_cyc = cyc;
                break;
            end
            tick();
        end
        check("done_seen", 64'(seen), 64'd1);
        check("ready_with_done", 64'(bus.ap_ready), 64'(seen));
        tick();
        check("done_one_cycle", 64'({bus.ap_done, bus.ap_ready, bus.ap_idle}), 64'd1);
    endtask

    task automatic check_out(input int first, input int cnt, input string tag);
        logic [63:0] act;
        check($sformatf("%s_count", tag), 64'(c_got.size()), 64'(cnt + 1));
        for (int i = 0; i <= cnt; i++) begin
            act = (i < c_got.size()) ? 64'(c_got[i]) : 64'hDEAD_BEEF_DEAD;
            if (i < cnt)
                check($sformatf("%s_c%0d", tag, i), act, 64'({1'b0, tbl[first+i].c}));
            else
                check($sformatf("%s_close", tag), act, 64'({1'b1, 32'd0}));
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        // basic run: A = B = 1..5, C = a[k] + b[k-1]
        tbl[0]  = '{32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000};
        tbl[1]  = '{32'h4000_0000, 32'h4000_0000, 32'h4040_0000};
        tbl[2]  = '{32'h4040_0000, 32'h4040_0000, 32'h40A0_0000};
        tbl[3]  = '{32'h4080_0000, 32'h4080_0000, 32'h40E0_0000};
        tbl[4]  = '{32'h40A0_0000, 32'h40A0_0000, 32'h4110_0000};
        // special values; each c pairs this a with the previous row's b
        tbl[5]  = '{32'h4020_0000, 32'hFF80_0000, 32'h4020_0000};
        tbl[6]  = '{32'h7F80_0000, 32'h7F7F_FFFF, 32'h7FC0_0000};
        tbl[7]  = '{32'h7F7F_FFFF, 32'hBFC0_0000, 32'h7F80_0000};
        tbl[8]  = '{32'h3FC0_0000, 32'h40E0_0000, 32'h0000_0000};
        tbl[9]  = '{32'h3F80_0000, 32'h3F00_0000, 32'h4100_0000};
        tbl[10] = '{32'hC040_0000, 32'h7FC0_0001, 32'hC020_0000};
        tbl[11] = '{32'h3F80_0000, 32'h0000_0001, 32'h7FC0_0000};
        tbl[12] = '{32'h8000_0000, 32'h3380_0000, 32'h0000_0000};
        tbl[13] = '{32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000};
        tbl[14] = '{32'h3F80_0001, 32'h8080_0001, 32'h3F80_0002};
        tbl[15] = '{32'h0080_0000, 32'h3F80_0000, 32'h8000_0000};
        tbl[16] = '{32'h4000_0000, 32'h1234_5678, 32'h4040_0000};

        bus.ap_start = 1'b0;
        bus.n        = 64'd0;
        flush();
        load(0, 5);
        repeat (2) @(negedge ap_clk);
        check("rst_idle",    64'(bus.ap_idle),   64'd1);
        check("rst_done",    64'(bus.ap_done),   64'd0);
        check("rst_ready",   64'(bus.ap_ready),  64'd0);
        check("rst_a_read",  64'(bus.a_s_read),  64'd0);
        check("rst_b_read",  64'(bus.b_s_read),  64'd0);
        check("rst_c_write", 64'(bus.c_s_write), 64'd0);
        check("rst_c_din",   64'(bus.c_s_din),   64'd0);
        check("rst_c_peek",  64'(bus.c_peek),    64'd0);
        ap_rst_n = 1'b1;
        tick();

        // basic run: 3 cycles per element plus READ(EoT), CLOSE, DONE
        flush();
        bus.n = 64'd5;
        load(0, 5);
        start_run();
        wait_done(60, dc);
        check("basic_cycles", 64'(dc), 64'd18);
        check_out(0, 5, "basic");

        // backpressure on C during WRITE
        flush();
        bus.n  = 64'd2;
        c_hold = 1;
        load(0, 2);
        start_run();
        for (int i = 0; i < 20 && bus.c_s_din != 33'h0_3F80_0000; i++) tick();
        check("bp_in_write", 64'(bus.c_s_din), 64'h0_3F80_0000);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_no_write", 64'(bus.c_s_write), 64'd0);
            check("bp_din_stable", 64'(bus.c_s_din), 64'h0_3F80_0000);
            check("bp_peek", 64'(bus.c_peek), 64'h0_3F80_0000);
            check("bp_no_pop", 64'(bus.a_s_read | bus.b_s_read), 64'd0);
        end
        check("bp_a_level", 64'(a_q.size()), 64'd2);
        check("bp_b_level", 64'(b_q.size()), 64'd2);
        check("bp_nothing_written", 64'(c_got.size()), 64'd0);
        c_hold = 0;
        refresh();
        wait_done(40, dc);
        check_out(0, 2, "bp");

        // starvation on B, then the special-value table
        flush();
        bus.n  = 64'd12;
        b_hold = 1;
        load(5, 12);
        start_run();
        for (int i = 0; i < 8; i++) begin
            tick();
            check("starve_a_read", 64'(bus.a_s_read), 64'd0);
            check("starve_b_read", 64'(bus.b_s_read), 64'd0);
        end
        check("starve_a_level", 64'(a_q.size()), 64'd13);
        b_hold = 0;
        refresh();
        wait_done(120, dc);
        check_out(5, 12, "fp");

        // reset during WRITE aborts, then a clean restart
        flush();
        bus.n = 64'd5;
        load(0, 5);
        start_run();
        for (int i = 0; i < 20 && !bus.c_s_write; i++) tick();
        check("mr_in_write", 64'(bus.c_s_write), 64'd1);
        #2;
        ap_rst_n = 1'b0;
        #1;
        check("mr_idle",    64'(bus.ap_idle),   64'd1);
        check("mr_done",    64'(bus.ap_done),   64'd0);
        check("mr_c_write", 64'(bus.c_s_write), 64'd0);
        check("mr_c_din",   64'(bus.c_s_din),   64'd0);
        check("mr_c_peek",  64'(bus.c_peek),    64'd0);
        check("mr_a_read",  64'(bus.a_s_read),  64'd0);
        tick();
        tick();
        check("mr_no_write", 64'(c_got.size()), 64'd0);
        ap_rst_n = 1'b1;
        flush();
        load(0, 5);
        start_run();
        wait_done(60, dc);
        check("mr_cycles", 64'(dc), 64'd18);
        check_out(0, 5, "mr");

        // both streams start with EoT
        flush();
        bus.n = 64'd0;
        load(0, 0);
        start_run();
        wait_done(20, dc);
        check("empty_cycles", 64'(dc), 64'd3);
        check_out(0, 0, "empty");

        // EoT on A only: both heads consumed, then close
        flush();
        a_q.push_back({1'b0, 32'h3F80_0000});
        a_q.push_back({1'b1, 32'd0});
        b_q.push_back({1'b0, 32'h3F80_0000});
        b_q.push_back({1'b0, 32'h4000_0000});
        b_q.push_back({1'b1, 32'd0});
        refresh();
        start_run();
        wait_done(30, dc);
        check_out(0, 1, "mis");
        check("mis_b_left", 64'(b_q.size()), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
